fifo_drain_rd: RTL and testbench

Read-side controller for the team's 8-bit push/pop FIFO.
- Pops bytes from the FIFO whenever it is non-empty and local buffer space allows.
- Absorbs the FIFO's registered read latency.
- Presents the bytes in order on a valid/ready stream toward downstream logic.
- Sits between the FIFO's pop/empty/dout side and any consumer, such as a serializer or checker.

---
 rtl/fifo_drain_rd.sv | 87 ++++++++
 tb/tb_fifo_drain_rd.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_rd.sv
// Read-side drain controller for the 8-bit push/pop FIFO: pops against local
// buffer credit, absorbs the FIFO read latency and replays bytes on a valid/ready stream.
module fifo_drain_rd #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [15:0]       rd_count
);
    localparam int BUF_DEPTH = RD_LAT + 2;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [CW:0]   CREDIT = (CW+1)'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST   = PW'(BUF_DEPTH - 1);

    logic [RD_LAT-1:0] pop_pipe;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     occ;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
    logic              cap;
    logic              xfer;

    assign cap  = pop_pipe[RD_LAT-1];
    assign xfer = m_valid & m_ready;

    // Credit counts every pop not yet delivered, so the buffer can never overflow.
    // rst is folded in so the pop request drops the instant reset is applied.
    assign fifo_pop = ~rst & en & ~fifo_empty
                      & (({1'b0, inflight} + {1'b0, occ}) < CREDIT);

    assign m_valid = (occ != '0);
    assign m_data  = m_valid ? buf_mem[rd_ptr] : '0;
    assign busy    = (inflight != '0) | m_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_pipe <= '0;
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_count <= '0;
        end else begin
            pop_pipe[0] <= fifo_pop;
            for (int i = 1; i < RD_LAT; i++) begin
                pop_pipe[i] <= pop_pipe[i-1];
            end
            inflight <= inflight + CW'(fifo_pop) - CW'(cap);
            occ      <= occ + CW'(cap) - CW'(xfer);
            if (cap) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (xfer) begin
                rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
                rd_count <= rd_count + 16'd1;
            end
        end
    end

    // Storage needs no reset: m_data is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (cap) begin
            buf_mem[wr_ptr] <= fifo_dout;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(fifo_pop && fifo_empty));
    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        occ <= CW'(BUF_DEPTH));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, inflight} + {1'b0, occ}) <= CREDIT);
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_fifo_drain_rd.sv
// Bench for fifo_drain_rd: behavioural FIFO, pop-order scoreboard and
// directed plus randomized drain/backpressure/enable/reset scenarios.
module tb_fifo_drain_rd;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = RD_LAT + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          m_ready = 1'b0;
    logic          fifo_pop;
    logic          m_valid;
    logic          busy;
    logic [DW-1:0] fifo_dout = '0;
    logic [DW-1:0] m_data;
    logic [15:0]   rd_count;

    always #5 clk = ~clk;

    fifo_drain_rd #(.DATA_W(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .fifo_dout(fifo_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .rd_count(rd_count)
    );

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] dly [RD_LAT];
    logic [15:0]   exp_cnt = '0;
    logic [DW-1:0] held = '0;
    logic          stalled = 1'b0;
    logic          pop_seen = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    int pop_cnt = 0;
    int xfer_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic push(input logic [DW-1:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural FIFO: a pop seen at an edge yields its byte RD_LAT cycles later;
    // every popped byte is what the stream must eventually deliver, in order.
    always @(posedge clk) begin
        #1;
        for (int i = RD_LAT - 1; i > 0; i--) dly[i] = dly[i-1];
        if (pop_seen && fifo_q.size() != 0) begin
            dly[0] = fifo_q.pop_front();
            exp_q.push_back(dly[0]);
            pop_cnt++;
        end
        fifo_dout  = dly[RD_LAT-1];
        fifo_empty = (fifo_q.size() == 0);
    end

    // Monitor: sampled mid-cycle, where the values seen are those at the next edge.
    always @(negedge clk) begin
        pop_seen = fifo_pop;
        if (rst) begin
            check("rst_pop", fifo_pop, 0);
            check("rst_valid", m_valid, 0);
            check("rst_data", m_data, 0);
            check("rst_busy", busy, 0);
            check("rst_count", rd_count, 0);
            exp_q.delete();
            exp_cnt = '0;
            stalled = 1'b0;
        end else begin
            if (fifo_pop) check("pop_while_empty", fifo_empty, 0);
            check("credit", exp_q.size() <= DEPTH, 1);
            check("busy", busy, exp_q.size() != 0);
            check("rd_count", rd_count, exp_cnt);
            if (stalled) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, held);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_byte", m_valid, 0);
                end else begin
                    check("data_order", m_data, exp_q.pop_front());
                    exp_cnt++;
                    xfer_cnt++;
                end
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int p0, x0, x1, n;
        logic [DW-1:0] pat [4];
        logic [15:0] cnt0;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

        // Reset with a non-empty FIFO, then backpressure
        for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) push(pat[i]);
        repeat (3) tick();
        p0 = pop_cnt; x0 = xfer_cnt;
        rst = 1'b0;
        @(negedge clk);
        check("first_pop_after_rst", fifo_pop, 1);
        repeat (10) tick();
        @(negedge clk);
        check("bp_pop_count", pop_cnt - p0, DEPTH);
        check("bp_pop_low", fifo_pop, 0);
        check("bp_valid", m_valid, 1);
        check("bp_data", m_data, 8'h11);
        tick();
        m_ready = 1'b1;
        repeat (20) tick();
        check("bp_pops_total", pop_cnt - p0, 8);
        check("bp_xfers_total", xfer_cnt - x0, 8);

        // Single byte latency
        cnt0 = exp_cnt;
        tick(); push(8'h11);
        @(negedge clk); check("single_pop", fifo_pop, 1);
        tick(); @(negedge clk);
        check("single_pop_once", fifo_pop, 0);
        check("single_valid_t1", m_valid, 0);
        tick(); @(negedge clk);
        check("single_valid_t2", m_valid, 1);
        check("single_data_t2", m_data, 8'h11);
        tick(); @(negedge clk);
        check("single_busy_after", busy, 0);
        check("single_count", rd_count, 32'(cnt0 + 16'd1));

        // Streaming at full rate
        x0 = xfer_cnt;
        tick();
        for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) push(pat[i]);
        repeat (2) tick();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", m_valid, 1);
            tick(); @(negedge clk);
        end
        check("stream_end", m_valid, 0);
        check("stream_xfers", xfer_cnt - x0, 8);

        // Enable drop after the second pop
        p0 = pop_cnt; x0 = xfer_cnt;
        tick(); for (int i = 0; i < 4; i++) push(pat[i]);
        @(negedge clk); check("en_pop1", fifo_pop, 1);
        tick(); @(negedge clk); check("en_pop2", fifo_pop, 1);
        tick(); en = 1'b0; @(negedge clk); check("en_pop_stop", fifo_pop, 0);
        repeat (6) tick();
        @(negedge clk);
        check("en_pops", pop_cnt - p0, 2);
        check("en_xfers", xfer_cnt - x0, 2);
        check("en_busy", busy, 0);
        tick(); en = 1'b1;
        repeat (10) tick();
        check("en_resume_xfers", xfer_cnt - x0, 4);

        // Reset with two bytes buffered and one in flight
        m_ready = 1'b0;
        p0 = pop_cnt;
        tick(); for (int i = 0; i < 4; i++) push(pat[i]);
        repeat (3) tick();
        check("mid_pops", pop_cnt - p0, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pop", fifo_pop, 0);
        repeat (2) tick();
        x1 = xfer_cnt;
        rst = 1'b0; m_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("mid_post_xfers", xfer_cnt - x1, 1);
        check("mid_post_count", rd_count, 16'd1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            tick();
            en      = ($urandom % 5) != 0;
            m_ready = ($urandom % 3) != 0;
            if (($urandom % 3) == 0) push(8'($urandom));
        end
        tick(); en = 1'b1; m_ready = 1'b1;
        n = 0;
        while (fifo_q.size() != 0 && n < 500) begin
            tick(); n++;
        end
        repeat (10) tick();
        @(negedge clk);
        check("drain_fifo_empty", fifo_q.size(), 0);
        check("drain_all_delivered", exp_q.size(), 0);
        check("drain_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
